// File: rtl/fifo_read.sv
// fifo_read: FIFO drain controller with settle delay, burst counter and FIFO_READ_CHECK_EN-guarded incrementing-pattern checker
module fifo_read #(
  parameter int DATA_W = 8,
  parameter int DELAY  = 10,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              almost_full,
  input  logic              almost_empty,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [7:0]        burst_cnt,
  output logic [15:0]       err_cnt,
  output logic              ae_seen
);
  localparam int CW = $clog2(DELAY + 2);
  localparam logic [CW-1:0] DLY_END = CW'(DELAY);
  localparam logic [CW-1:0] DRN_END = CW'(RD_LAT - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_DELAY = 2'd1, S_READ = 2'd2, S_DRAIN = 2'd3;
  logic [1:0] state, nxt;
  logic [CW-1:0] delay_cnt;
  logic af_d0, af_d1, af_rise;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT:0] vld_sh;
  logic cap, start, done;
  assign fifo_rd_en = (state == S_READ) & ~fifo_empty & ~sys_rst;
  assign vld_sh = {vld_pipe, fifo_rd_en};
  assign cap = vld_sh[RD_LAT];
  assign start = (state == S_IDLE) & af_rise;
  assign done = (state == S_DRAIN) & (delay_cnt == DRN_END);
  always_comb
    nxt = state == S_IDLE  ? (af_rise ? S_DELAY : S_IDLE) :
          state == S_DELAY ? (delay_cnt == DLY_END ? S_READ : S_DELAY) :
          state == S_READ  ? (fifo_empty ? S_DRAIN : S_READ) :
          (done ? S_IDLE : S_DRAIN);
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state     <= S_IDLE;
      delay_cnt <= '0;
      af_d0     <= 1'b0;
      af_d1     <= 1'b0;
      af_rise   <= 1'b0;
      vld_pipe  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      burst_cnt <= '0;
      ae_seen   <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= nxt != S_IDLE;
      delay_cnt <= ((state == S_DELAY) | (state == S_DRAIN)) & (nxt == state) ? delay_cnt + 1'b1 : '0;
      af_d0     <= almost_full;
      af_d1     <= af_d0;
      af_rise   <= af_d0 & ~af_d1;
      vld_pipe  <= vld_sh[RD_LAT-1:0];
      rd_valid  <= cap;
      if (cap) rd_data <= fifo_rdata;
      if (done) burst_cnt <= burst_cnt + 1'b1;
      ae_seen   <= start ? 1'b0 : ae_seen | ((state == S_READ) & almost_empty);
    end
`ifdef FIFO_READ_CHECK_EN
  logic [DATA_W-1:0] exp;
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      exp     <= '0;
      err_cnt <= '0;
    end else if (cap) begin
      exp <= fifo_rdata + 1'b1;
      if (fifo_rdata != exp && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end else if (start) begin
      exp <= '0;
    end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_read.sv
// tb_fifo_read: scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances of fifo_read from shared burst stimulus
module tb_fifo_read;
  localparam int DELAY = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sys_rst = 1'b1, almost_full = 1'b0, almost_empty = 1'b0;
  logic [1:0] fifo_empty = 2'b11;
  logic [1:0] fifo_rd_en, rd_valid, busy, ae_seen;
  logic [7:0] fifo_rdata [2];
  logic [7:0] rd_data [2];
  logic [7:0] burst_cnt [2];
  logic [15:0] err_cnt [2];
  logic [7:0] mem [2][$];
  logic [7:0] sb [2][$];
  logic [7:0] ld [$];
  logic [7:0] d0 [2] = '{8'd0, 8'd0};
  logic [7:0] d1 [2] = '{8'd0, 8'd0};
  int checks = 0, errors = 0;
  int exp_err = 0, exp_bursts = 0;

  fifo_read #(.DATA_W(8), .DELAY(DELAY), .RD_LAT(1)) u_lat1 (
    .sys_clk(clk), .sys_rst(sys_rst), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_empty(fifo_empty[0]), .fifo_rdata(fifo_rdata[0]), .fifo_rd_en(fifo_rd_en[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0]), .burst_cnt(burst_cnt[0]),
    .err_cnt(err_cnt[0]), .ae_seen(ae_seen[0]));

  fifo_read #(.DATA_W(8), .DELAY(DELAY), .RD_LAT(2)) u_lat2 (
    .sys_clk(clk), .sys_rst(sys_rst), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_empty(fifo_empty[1]), .fifo_rdata(fifo_rdata[1]), .fifo_rd_en(fifo_rd_en[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1]), .burst_cnt(burst_cnt[1]),
    .err_cnt(err_cnt[1]), .ae_seen(ae_seen[1]));

  always @(posedge clk) begin
    logic [1:0] re;
    re = fifo_rd_en;
    #1;
    for (int l = 0; l < 2; l++) begin
      d1[l] = d0[l];
      if (re[l] && mem[l].size() > 0) d0[l] = mem[l].pop_front();
    end
    fifo_rdata[0] = d0[0];
    fifo_rdata[1] = d1[1];
    fifo_empty = {mem[1].size() == 0, mem[0].size() == 0};
  end

  always @(negedge clk) begin
    logic [7:0] w;
    for (int l = 0; l < 2; l++) begin
      if (fifo_rd_en[l]) begin
        checks++;
        if (fifo_empty[l]) begin
          errors++;
          $display("FAIL rd_while_empty lane%0d: fifo_rd_en=1 with fifo_empty=1, required 0", l);
        end
      end
      if (rd_valid[l]) begin
        checks++;
        if (sb[l].size() == 0) begin
          errors++;
          $display("FAIL sb_extra lane%0d: got rd_data=%0d, expected no word", l, rd_data[l]);
        end else begin
          w = sb[l].pop_front();
          if (rd_data[l] !== w) begin
            errors++;
            $display("FAIL sb_data lane%0d: got %0d, expected %0d", l, rd_data[l], w);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic chk_zero(input int l, input string tag);
    chk($sformatf("%s_l%0d_rd_en", tag, l), int'(fifo_rd_en[l]), 0);
    chk($sformatf("%s_l%0d_rd_valid", tag, l), int'(rd_valid[l]), 0);
    chk($sformatf("%s_l%0d_busy", tag, l), int'(busy[l]), 0);
    chk($sformatf("%s_l%0d_burst_cnt", tag, l), int'(burst_cnt[l]), 0);
    chk($sformatf("%s_l%0d_err_cnt", tag, l), int'(err_cnt[l]), 0);
    chk($sformatf("%s_l%0d_ae_seen", tag, l), int'(ae_seen[l]), 0);
    chk($sformatf("%s_l%0d_rd_data", tag, l), int'(rd_data[l]), 0);
  endtask

  function automatic int pattern_errs();
    int e = 0;
    logic [7:0] x = 8'd0;
    foreach (ld[i]) begin
      if (ld[i] != x) e++;
      x = ld[i] + 8'd1;
    end
    return e;
  endfunction

  function automatic int want_err();
`ifdef FIFO_READ_CHECK_EN
    return exp_err > 65535 ? 65535 : exp_err;
`else
    return 0;
`endif
  endfunction

  task automatic fill(input int first, input int n);
    ld = {};
    for (int i = 0; i < n; i++) ld.push_back(8'(first + i));
  endtask

  task automatic load();
    foreach (ld[i]) for (int l = 0; l < 2; l++) begin
      mem[l].push_back(ld[i]);
      sb[l].push_back(ld[i]);
    end
    exp_err += pattern_errs();
    exp_bursts = (exp_bursts + 1) % 256;
  endtask

  task automatic flush();
    for (int l = 0; l < 2; l++) begin
      mem[l].delete();
      sb[l].delete();
    end
  endtask

  task automatic burst(input string tag, input bit chk_lat, input bit retrig, input bit ae_pulse);
    int lat;
    int reads [2];
    int rise [2];
    int idle [2];
    bit seen [2];
    bit prev_e [2];
    @(negedge clk);
    load();
    @(negedge clk);
    lat = -1;
    for (int l = 0; l < 2; l++) begin
      reads[l] = 0; rise[l] = -1; idle[l] = -1; seen[l] = 0; prev_e[l] = fifo_empty[l];
    end
    almost_full = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (lat < 0 && fifo_rd_en[0]) lat = n;
      if (retrig && n >= 16 && n < 24) almost_full = (n % 2 == 1);
      almost_empty = ae_pulse && n == 18;
      for (int l = 0; l < 2; l++) begin
        reads[l] += int'(fifo_rd_en[l]);
        if (busy[l]) seen[l] = 1;
        if (seen[l] && fifo_empty[l] && !prev_e[l] && rise[l] < 0) rise[l] = n;
        if (seen[l] && !busy[l] && idle[l] < 0) idle[l] = n;
        prev_e[l] = fifo_empty[l];
      end
      if (idle[0] >= 0 && idle[1] >= 0) break;
    end
    almost_full = 1'b0;
    almost_empty = 1'b0;
    if (chk_lat) chk({tag, "_first_rd_en"}, lat, DELAY + 3);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_l%0d_done", tag, l), int'(idle[l] >= 0), 1);
      chk($sformatf("%s_l%0d_reads", tag, l), reads[l], ld.size());
      chk($sformatf("%s_l%0d_burst_cnt", tag, l), int'(burst_cnt[l]), exp_bursts);
      chk($sformatf("%s_l%0d_err_cnt", tag, l), int'(err_cnt[l]), want_err());
      chk($sformatf("%s_l%0d_ae_seen", tag, l), int'(ae_seen[l]), int'(ae_pulse));
      chk($sformatf("%s_l%0d_words_left", tag, l), sb[l].size(), 0);
      if (rise[l] >= 0) chk($sformatf("%s_l%0d_busy_drop", tag, l), idle[l] - rise[l], l + 2);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] x;
    int n;
    sys_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      almost_full = 1'($urandom);
      almost_empty = 1'($urandom);
      for (int l = 0; l < 2; l++) begin
        if (i % 2 == 0) mem[l].push_back(8'($urandom)); else mem[l].delete();
        chk_zero(l, "reset");
      end
    end
    @(negedge clk);
    sys_rst = 1'b0;
    almost_full = 1'b0;
    almost_empty = 1'b0;
    flush();
    repeat (3) @(negedge clk);

    fill(0, 16);
    burst("nominal", 1, 0, 0);
    ld = {8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9};
    burst("corrupt", 1, 0, 0);
    for (int l = 0; l < 2; l++) chk($sformatf("corrupt_l%0d_last_data", l), int'(rd_data[l]), 9);
    fill(0, 16);
    burst("retrig", 0, 1, 0);
    fill(0, 4);
    burst("after_retrig", 1, 0, 0);
    ld = {};
    burst("empty_read", 0, 0, 0);
    fill(0, 258);
    burst("wrap", 1, 0, 0);
    fill(0, 16);
    burst("ae_pulse", 0, 0, 1);
    fill(0, 16);
    burst("ae_clear", 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 20);
      ld = {};
      x = 8'd0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) x = 8'($urandom);
        ld.push_back(x);
        x = x + 8'd1;
      end
      burst($sformatf("random%0d", k), 1, 0, 0);
    end

    @(negedge clk);
    fill(0, 16);
    load();
    @(negedge clk);
    almost_full = 1'b1;
    @(posedge clk);
    repeat (19) @(negedge clk);
    chk("midrst_pre_rd_en", int'(fifo_rd_en[0]), 1);
    sys_rst = 1'b1;
    #1;
    for (int l = 0; l < 2; l++) chk($sformatf("midrst_l%0d_rd_en_same_cycle", l), int'(fifo_rd_en[l]), 0);
    @(negedge clk);
    for (int l = 0; l < 2; l++) chk_zero(l, "midrst");
    sys_rst = 1'b0;
    almost_full = 1'b0;
    flush();
    exp_bursts = 0;
    exp_err = 0;
    @(negedge clk);
    for (int l = 0; l < 2; l++) chk($sformatf("midrst_l%0d_no_inflight", l), int'(rd_valid[l]), 0);
    repeat (3) @(negedge clk);
    fill(0, 8);
    burst("recover", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
